// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states and bit-timing constants.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  localparam int OVERSAMPLE   = 16;
  localparam int DATA_BITS    = 8;
  // Mid-bit of the start bit: the 8th oversample tick after the falling edge.
  localparam int START_SAMPLE = 7;
  // Mid-bit of every following bit: 16 ticks after the previous sample.
  localparam int BIT_SAMPLE   = 15;

endpackage

// File: rtl/baud_tick_gen.sv
// Oversample tick generator: one-clk b_tick every CLK_FREQ/(BAUD*OVERSAMPLE) clocks.
// Latency: free-running from reset; first tick DIV clocks after reset release.
// Backpressure: none; the consumer must take every tick.
module baud_tick_gen #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic rst,
  output logic b_tick
);

  localparam int DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;

  // Divide clk down to the oversample rate; the tick is registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      b_tick <= 1'b0;
    end else if (cnt == CW'(DIV - 1)) begin
      cnt    <= '0;
      b_tick <= 1'b1;
    end else begin
      cnt    <= cnt + CW'(1);
      b_tick <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1 LSB first, 16x oversampled; optional even parity (UART_RX_PARITY_EN).
// Latency: rx_done ~9.5 bit times after start-bit fall, +2 sync clks, +<=1 tick jitter.
// Backpressure: none; rx_done/frame_err are single-cycle strobes, rx_data held until next good byte.
module uart_rx #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_done,
  output logic       rx_busy,
  output logic       frame_err
);

  import uart_pkg::*;

  rx_state_t  state, state_n;
  logic [3:0] tick_cnt, tick_n;
  logic [2:0] bit_cnt, bit_n;
  logic [7:0] shift, shift_n;
  logic [7:0] data_n;
  logic       armed, armed_n;
  logic       done_n, ferr_n;
  logic       rx_meta, rx_s;
  logic       b_tick;
`ifdef UART_RX_PARITY_EN
  logic       par_err, par_err_n;
`endif

  baud_tick_gen #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD       (BAUD),
    .OVERSAMPLE (OVERSAMPLE)
  ) u_tick (
    .clk    (clk),
    .rst    (rst),
    .b_tick (b_tick)
  );

  // Two-flop synchroniser; resets to the idle (high) line level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // State and datapath registers; rx_busy follows the next state so it aligns with state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      shift     <= '0;
      armed     <= 1'b0;
      rx_data   <= '0;
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
      rx_busy   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err   <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      tick_cnt  <= tick_n;
      bit_cnt   <= bit_n;
      shift     <= shift_n;
      armed     <= armed_n;
      rx_data   <= data_n;
      rx_done   <= done_n;
      frame_err <= ferr_n;
      rx_busy   <= (state_n != IDLE);
`ifdef UART_RX_PARITY_EN
      par_err   <= par_err_n;
`endif
    end
  end

  // Next-state and strobe logic; every sample point is a mid-bit tick.
  always_comb begin
    state_n = state;
    tick_n  = tick_cnt;
    bit_n   = bit_cnt;
    shift_n = shift;
    armed_n = armed;
    data_n  = rx_data;
    done_n  = 1'b0;
    ferr_n  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_err_n = par_err;
`endif
    case (state)
      IDLE: begin
        // Only a high-to-low transition starts a frame, so a held break
        // after a bad stop bit cannot retrigger.
        tick_n = '0;
        if (armed && !rx_s) begin
          state_n = START;
        end else if (rx_s) begin
          armed_n = 1'b1;
        end
      end
      START: begin
        if (b_tick) begin
          if (tick_cnt == 4'(START_SAMPLE)) begin
            tick_n = '0;
            if (!rx_s) begin
              state_n = DATA;
              bit_n   = '0;
            end else begin
              state_n = IDLE;
              armed_n = 1'b0;
            end
          end else begin
            tick_n = tick_cnt + 4'd1;
          end
        end
      end
      DATA: begin
        if (b_tick) begin
          // 4-bit counter wraps 15 -> 0, giving a 16-tick bit period.
          tick_n = tick_cnt + 4'd1;
          if (tick_cnt == 4'(BIT_SAMPLE)) begin
            shift_n = {rx_s, shift[7:1]};
            bit_n   = bit_cnt + 3'd1;
            if (bit_cnt == 3'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
              state_n = PARITY;
`else
              state_n = STOP;
`endif
            end
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (b_tick) begin
          tick_n = tick_cnt + 4'd1;
          if (tick_cnt == 4'(BIT_SAMPLE)) begin
            // Even parity: data bits plus parity bit must have an even count of ones.
            par_err_n = (^shift) ^ rx_s;
            state_n   = STOP;
          end
        end
      end
`endif
      STOP: begin
        if (b_tick) begin
          tick_n = tick_cnt + 4'd1;
          if (tick_cnt == 4'(BIT_SAMPLE)) begin
            // Leave at mid-stop so an immediately following start bit is caught.
            state_n = IDLE;
            armed_n = 1'b0;
`ifdef UART_RX_PARITY_EN
            if (rx_s && !par_err) begin
`else
            if (rx_s) begin
`endif
              data_n = shift;
              done_n = 1'b1;
            end else begin
              ferr_n = 1'b1;
            end
          end
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule
